// File: rtl/l1_mem_arbiter_pkg.sv
// Shared memory-link types for the L1 memory arbiter: line address, write line,
// response word, client index and arbiter state.
package Mem;
    localparam int LINEADDR_BITS = 28;
    localparam int LINE_BITS     = 128;
    localparam int WORD_BITS     = 32;
    localparam int MAX_CLIENTS   = 16;

    typedef logic [LINEADDR_BITS-1:0]       lineaddr_t;
    typedef logic [LINE_BITS-1:0]           line_t;
    typedef logic [WORD_BITS-1:0]           w_t;
    typedef logic [$clog2(MAX_CLIENTS)-1:0] cli_idx_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } arb_state_e;
endpackage

// File: rtl/l1_mem_arbiter_rr_arbiter.sv
// Combinational round-robin picker: returns the first requesting client at or
// after i_rr_ptr, wrapping cyclically, plus a flag that any client is requesting.
module rr_arbiter
    import Mem::*;
#(
    parameter int NUM_CLIENTS = 2
) (
    input  logic [NUM_CLIENTS-1:0] i_req,
    input  cli_idx_t               i_rr_ptr,
    output cli_idx_t               o_grant,
    output logic                   o_any_valid
);
    logic [NUM_CLIENTS-1:0] w_mask;
    logic [NUM_CLIENTS-1:0] w_req_hi;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CLIENTS; gi++) begin : g_mask
            assign w_mask[gi] = (cli_idx_t'(gi) >= i_rr_ptr);
        end
    endgenerate

    assign w_req_hi    = i_req & w_mask;
    assign o_any_valid = |i_req;

    // Lowest request overall is the wrap-around fallback; lowest at/after the pointer wins if present.
    always_comb begin
        o_grant = '0;
        for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
            if (i_req[i]) o_grant = cli_idx_t'(i);
        end
        for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
            if (w_req_hi[i]) o_grant = cli_idx_t'(i);
        end
    end
endmodule

// File: rtl/l1_mem_arbiter.sv
// Round-robin arbiter of NUM_CLIENTS L1 memory ports onto one memory port, one
// transaction in flight. Define MEMARB_PERF_EN to add per-client perf counters.
module l1_mem_arbiter
    import Mem::*;
#(
    parameter int NUM_CLIENTS = 2,
    parameter int ADDR_W      = $bits(Mem::lineaddr_t),
    parameter int LINE_W      = $bits(Mem::line_t),
    parameter int WORD_W      = $bits(Mem::w_t),
    parameter int CNT_W       = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CLIENTS-1:0]        cli_req_valid,
    input  logic [NUM_CLIENTS-1:0]        cli_req_we,
    input  logic [NUM_CLIENTS*ADDR_W-1:0] cli_req_addr,
    input  logic [NUM_CLIENTS*LINE_W-1:0] cli_req_data,
    output logic [NUM_CLIENTS-1:0]        cli_req_ready,
    output logic [NUM_CLIENTS-1:0]        cli_resp_ack,
    output logic [WORD_W-1:0]             cli_resp_data,
    output logic                          mem_req_valid,
    output logic                          mem_req_we,
    output logic [ADDR_W-1:0]             mem_req_addr,
    output logic [LINE_W-1:0]             mem_req_data,
    input  logic                          mem_req_ready,
    input  logic                          mem_resp_ack,
    input  logic [WORD_W-1:0]             mem_resp_data
`ifdef MEMARB_PERF_EN
    ,
    output logic [NUM_CLIENTS*CNT_W-1:0]  perf_grants,
    output logic [NUM_CLIENTS*CNT_W-1:0]  perf_wait
`endif
);
    arb_state_e             r_state;
    cli_idx_t               r_grant;
    cli_idx_t               r_rr_ptr;
    logic                   r_seen_grant;

    cli_idx_t               w_arb_grant;
    logic                   w_any_valid;
    logic [NUM_CLIENTS-1:0] w_grant_oh;
    logic                   w_accept;
    logic                   w_done;
    logic                   w_sel_valid;
    cli_idx_t               w_next_ptr;

    rr_arbiter #(
        .NUM_CLIENTS (NUM_CLIENTS)
    ) u_rr_arbiter (
        .i_req       (cli_req_valid),
        .i_rr_ptr    (r_rr_ptr),
        .o_grant     (w_arb_grant),
        .o_any_valid (w_any_valid)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CLIENTS; gi++) begin : g_route
            assign w_grant_oh[gi]    = (r_grant == cli_idx_t'(gi));
            assign cli_req_ready[gi] = w_accept && w_grant_oh[gi];
            assign cli_resp_ack[gi]  = w_done && w_grant_oh[gi];
        end
    endgenerate

    assign w_accept      = (r_state == REQ) && mem_req_ready;
    assign w_done        = (w_accept && mem_resp_ack) || ((r_state == WAIT) && mem_resp_ack);
    assign w_sel_valid   = |(cli_req_valid & w_grant_oh);
    assign w_next_ptr    = (r_grant == cli_idx_t'(NUM_CLIENTS - 1)) ? '0 : r_grant + cli_idx_t'(1);
    assign mem_req_valid = (r_state == REQ);
    assign cli_resp_data = mem_resp_data;

    always_comb begin
        mem_req_we   = 1'b0;
        mem_req_addr = '0;
        mem_req_data = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (w_grant_oh[i]) begin
                mem_req_we   = cli_req_we[i];
                mem_req_addr = cli_req_addr[i*ADDR_W +: ADDR_W];
                mem_req_data = cli_req_data[i*LINE_W +: LINE_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_rr_ptr     <= '0;
            r_seen_grant <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_valid) begin
                        r_grant      <= w_arb_grant;
                        r_state      <= REQ;
                        r_seen_grant <= 1'b1;
                    end
                end
                REQ: begin
                    if (mem_req_ready) r_state <= mem_resp_ack ? IDLE : WAIT;
                end
                WAIT: begin
                    if (mem_resp_ack) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
            if (w_done) r_rr_ptr <= w_next_ptr;
        end
    end

    // Stale acks straight after reset belong to an abandoned transaction and are tolerated.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == REQ) assert (w_sel_valid);
            if ((r_state == REQ) && !mem_req_ready) assert (!mem_resp_ack);
            if ((r_state == IDLE) && r_seen_grant) assert (!mem_resp_ack);
        end
    end

`ifdef MEMARB_PERF_EN
    logic [CNT_W-1:0] r_perf_grants [NUM_CLIENTS];
    logic [CNT_W-1:0] r_perf_wait   [NUM_CLIENTS];

    generate
        for (gi = 0; gi < NUM_CLIENTS; gi++) begin : g_perf
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_perf_grants[gi] <= '0;
                    r_perf_wait[gi]   <= '0;
                end else begin
                    if (cli_req_ready[gi] && (r_perf_grants[gi] != '1))
                        r_perf_grants[gi] <= r_perf_grants[gi] + CNT_W'(1);
                    if (cli_req_valid[gi] && !((r_state == REQ) && w_grant_oh[gi])
                            && (r_perf_wait[gi] != '1))
                        r_perf_wait[gi] <= r_perf_wait[gi] + CNT_W'(1);
                end
            end
            assign perf_grants[gi*CNT_W +: CNT_W] = r_perf_grants[gi];
            assign perf_wait[gi*CNT_W +: CNT_W]   = r_perf_wait[gi];
        end
    endgenerate
`else
    logic [CNT_W-1:0] w_unused_cnt;
    assign w_unused_cnt = '0;
`endif
endmodule
